// File: rtl/knight_ctrl.sv
`default_nettype none
// ============================================================================
// knight_ctrl : knight-scanner LED sequencer (prescaler, direction FSM, modes)
// Revision    : 1.0
// ============================================================================
module knight_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             ck,
    input  logic             res,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             step
);

    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2((DIV << 3) + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             ph_q, ph_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       speed_q, speed_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             step_q, step_d;

    logic [CW-1:0]    period_w;
    logic             tick_w;

    assign period_w = CW'(DIV) << speed_q;
    assign tick_w   = (cnt_q == (period_w - CW'(1)));

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        speed_d = speed_q;
        out_d   = out_q;
        step_d  = 1'b0;

        if (state_q == IDLE) begin
            if (start && !stop) begin
                state_d = LEFT;
                pos_d   = '0;
                cnt_d   = '0;
                ph_d    = 1'b1;
                mode_d  = mode;
                speed_d = speed;
                out_d   = (mode == 2'd2) ? {WIDTH{1'b1}} : WIDTH'(1);
            end
        end else if (stop) begin
            state_d = IDLE;
            out_d   = '0;
            cnt_d   = '0;
        end else if (!hold) begin
            if (tick_w) begin
                cnt_d  = '0;
                step_d = 1'b1;
                case (mode_q)
                    2'd1: begin
                        state_d = LEFT;
                        pos_d   = (pos_q == PW'(WIDTH - 1)) ? '0 : pos_q + PW'(1);
                        out_d   = WIDTH'(1) << pos_d;
                    end
                    2'd2: begin
                        ph_d  = ~ph_q;
                        out_d = {WIDTH{ph_d}};
                    end
                    default: begin
                        // Bounce: end LEDs are shown once, then direction flips.
                        if (state_q == LEFT) begin
                            if (pos_q == PW'(WIDTH - 1)) begin
                                state_d = RIGHT;
                                pos_d   = PW'(WIDTH - 2);
                            end else begin
                                pos_d = pos_q + PW'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                state_d = LEFT;
                                pos_d   = PW'(1);
                            end else begin
                                pos_d = pos_q - PW'(1);
                            end
                        end
                        out_d = WIDTH'(1) << pos_d;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            pos_q   <= '0;
            ph_q    <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 2'd0;
            speed_q <= 2'd0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign step = step_q;

endmodule
`default_nettype wire

// File: tb/tb_knight_ctrl.sv
`default_nettype none
// ============================================================================
// tb_knight_ctrl : directed self-checking bench for knight_ctrl (WIDTH=8, DIV=2)
// Revision       : 1.0
// ============================================================================
module tb_knight_ctrl;

    logic       ck = 1'b0;
    logic       res = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] speed = 2'd0;
    logic [7:0] out;
    logic       busy;
    logic       step;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] bseq [0:15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    knight_ctrl #(.WIDTH(8), .DIV(2)) dut (
        .ck    (ck),
        .res   (res),
        .start (start),
        .stop  (stop),
        .hold  (hold),
        .mode  (mode),
        .speed (speed),
        .out   (out),
        .busy  (busy),
        .step  (step)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge ck);
    endtask

    // Pulse start for one edge; returns at the negedge after the sampling edge.
    task automatic do_start(input logic [1:0] m, input logic [1:0] s);
        mode  = m;
        speed = s;
        start = 1'b1;
        nclk(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        nclk(1);
        stop = 1'b0;
    endtask

    initial begin
        // Reset state
        nclk(1);
        check("rst_out", out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_step", step, 1'b0);
        res = 1'b1;
        nclk(2);
        check("idle_busy", busy, 1'b0);

        // Bounce scan, P=2
        do_start(2'd0, 2'd0);
        check("b_init_out", out, 8'h01);
        check("b_init_busy", busy, 1'b1);
        check("b_init_step", step, 1'b0);
        for (int k = 1; k < 16; k++) begin
            nclk(1);
            check("b_mid_out", out, bseq[k-1]);
            check("b_mid_step", step, 1'b0);
            nclk(1);
            check("b_adv_out", out, bseq[k]);
            check("b_adv_step", step, 1'b1);
        end
        do_stop();
        check("b_stop_out", out, 8'h00);
        check("b_stop_busy", busy, 1'b0);

        // Wrap scan, P=8
        do_start(2'd1, 2'd2);
        check("w_init_out", out, 8'h01);
        for (int k = 1; k <= 9; k++) begin
            nclk(7);
            check("w_mid_out", out, 32'(8'h01 << ((k - 1) % 8)));
            check("w_mid_step", step, 1'b0);
            nclk(1);
            check("w_adv_out", out, 32'(8'h01 << (k % 8)));
            check("w_adv_step", step, 1'b1);
            check("w_busy", busy, 1'b1);
        end
        // start while busy must not switch to blink nor restart
        do_start(2'd2, 2'd0);
        check("w_ign_out", out, 8'h02);
        nclk(6);
        check("w_ign_mid", out, 8'h02);
        nclk(1);
        check("w_ign_adv", out, 8'h04);
        check("w_ign_step", step, 1'b1);
        do_stop();
        check("w_stop_busy", busy, 1'b0);

        // Blink, P=2
        do_start(2'd2, 2'd0);
        check("k_init_out", out, 8'hFF);
        for (int k = 1; k <= 4; k++) begin
            nclk(1);
            check("k_mid_step", step, 1'b0);
            nclk(1);
            check("k_adv_out", out, (k % 2 == 1) ? 32'h00 : 32'hFF);
            check("k_adv_step", step, 1'b1);
        end
        do_stop();
        check("k_stop_out", out, 8'h00);

        // Hold for 5 cycles stretches the step, then stop on a tick
        do_start(2'd0, 2'd0);
        nclk(2);
        check("h_pre_out", out, 8'h02);
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            nclk(1);
            check("h_hold_out", out, 8'h02);
            check("h_hold_step", step, 1'b0);
        end
        hold = 1'b0;
        nclk(1);
        check("h_rel_out", out, 8'h02);
        check("h_rel_step", step, 1'b0);
        nclk(1);
        check("h_adv_out", out, 8'h04);
        check("h_adv_step", step, 1'b1);
        nclk(1);
        do_stop();
        check("st_tick_out", out, 8'h00);
        check("st_tick_step", step, 1'b0);
        check("st_tick_busy", busy, 1'b0);

        // start + stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        nclk(1);
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", busy, 1'b0);
        check("ss_out", out, 8'h00);

        // Async reset mid-scan at out=20
        do_start(2'd0, 2'd0);
        nclk(10);
        check("r_pre_out", out, 8'h20);
        check("r_pre_step", step, 1'b1);
        #1 res = 1'b0;
        #1;
        check("r_async_out", out, 8'h00);
        check("r_async_busy", busy, 1'b0);
        check("r_async_step", step, 1'b0);
        #1 res = 1'b1;
        nclk(5);
        check("r_post_busy", busy, 1'b0);
        check("r_post_out", out, 8'h00);
        do_start(2'd0, 2'd0);
        check("r_restart_out", out, 8'h01);
        check("r_restart_busy", busy, 1'b1);
        do_stop();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
